// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared TileLink-UL definitions for the RAM responder slice: channel opcodes,
// bus width constants and the packed D-channel response record that the
// responder keeps in its output register.
// -----------------------------------------------------------------------------
package tl_pkg;

  localparam int ADDR_W = 36;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 3;

  // A-channel request opcodes understood by this endpoint
  typedef enum logic [2:0] {
    TL_A_PUTFULL    = 3'd0,
    TL_A_PUTPARTIAL = 3'd1,
    TL_A_GET        = 3'd4
  } tl_a_op_e;

  // D-channel response opcodes produced by this endpoint
  typedef enum logic [2:0] {
    TL_D_ACCESSACK     = 3'd0,
    TL_D_ACCESSACKDATA = 3'd1
  } tl_d_op_e;

  // Everything the D channel presents besides valid
  typedef struct packed {
    logic [2:0]        opcode;
    logic [SIZE_W-1:0] size;
    logic              source;
    logic              denied;
    logic [DATA_W-1:0] data;
  } tl_d_rsp_t;

endpackage

// File: rtl/tl_ram_array.sv
// -----------------------------------------------------------------------------
// tl_ram_array
// DEPTH x 64-bit word storage with per-byte write enables. The read port is
// combinational on the same index as the write port, so a read in the cycle of
// a write returns the word as it stood before that edge. Storage has no reset.
//
// Ports:
//   clock    - write clock
//   we_i     - write enable for this cycle
//   idx_i    - word index shared by read and write
//   mask_i   - byte lanes to write
//   wdata_i  - write data
//   rdata_o  - current (pre-write) contents of word idx_i
// -----------------------------------------------------------------------------
module tl_ram_array
  import tl_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [MASK_W-1:0] mask_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear mask bit keep their old contents
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (mask_i[i]) begin
          mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/tl_ram_responder.sv
// -----------------------------------------------------------------------------
// tl_ram_responder
// TileLink-UL leaf slave: accepts single-beat Get / PutFullData /
// PutPartialData requests on the A channel and answers each one on the D
// channel the cycle after acceptance, backed by a local word-addressed RAM.
// Requests that fall outside the decoded window, are misaligned, have an
// oversized size or an unknown opcode are answered with denied=1 and never
// touch the RAM.
//
// Ports:
//   clock, reset              - clock and asynchronous active-low reset
//   auto_in_a_*               - A channel (request) from the upstream buffer
//   auto_in_d_*               - D channel (response) back to the requester
// -----------------------------------------------------------------------------
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 36'h0_8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [SIZE_W-1:0] auto_in_a_bits_size,
  input  logic              auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [SIZE_W-1:0] auto_in_d_bits_size,
  output logic              auto_in_d_bits_source,
  output logic              auto_in_d_bits_denied,
  output logic [DATA_W-1:0] auto_in_d_bits_data
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 8);

  logic              dValid_q, dValid_d;
  tl_d_rsp_t         rsp_q, rsp_d;

  logic              aFire;
  logic [ADDR_W-1:0] offset;
  logic              inRange;
  logic              sizeOk;
  logic              aligned;
  logic              opOk;
  logic              isGet;
  logic              denied;
  logic              ramWe;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] ramRdata;

  // The response register can take a new entry whenever it is empty or being
  // drained this cycle, which gives full throughput without a skid buffer.
  assign auto_in_a_ready = !dValid_q || auto_in_d_ready;
  assign aFire           = auto_in_a_valid && auto_in_a_ready;

  // An address below the base wraps to a huge offset, so a single unsigned
  // compare covers both ends of the window. Because the base is aligned to
  // the window size, the offset's low bits equal the address's low bits.
  assign offset  = auto_in_a_bits_address - BASE_ADDR;
  assign inRange = offset < SPAN;
  assign idx     = offset[IDX_W+2:3];
  assign isGet   = auto_in_a_bits_opcode == TL_A_GET;
  assign opOk    = (auto_in_a_bits_opcode == TL_A_PUTFULL) ||
                   (auto_in_a_bits_opcode == TL_A_PUTPARTIAL) || isGet;

  // Natural alignment to 2^size; sizes above one full word are illegal
  always_comb begin
    sizeOk  = 1'b1;
    aligned = 1'b0;
    case (auto_in_a_bits_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (offset[0] == 1'b0);
      3'd2:    aligned = (offset[1:0] == 2'b00);
      3'd3:    aligned = (offset[2:0] == 3'b000);
      default: sizeOk  = 1'b0;
    endcase
  end

  assign denied = !(inRange && sizeOk && aligned && opOk);
  assign ramWe  = aFire && !denied && !isGet;

  tl_ram_array #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .we_i    (ramWe),
    .idx_i   (idx),
    .mask_i  (auto_in_a_bits_mask),
    .wdata_i (auto_in_a_bits_data),
    .rdata_o (ramRdata)
  );

  // Next response: a new request always wins over a drain so that a
  // simultaneous A fire and D fire keeps d_valid high with fresh contents.
  always_comb begin
    dValid_d = dValid_q;
    rsp_d    = rsp_q;
    if (aFire) begin
      dValid_d     = 1'b1;
      rsp_d.opcode = isGet ? TL_D_ACCESSACKDATA : TL_D_ACCESSACK;
      rsp_d.size   = auto_in_a_bits_size;
      rsp_d.source = auto_in_a_bits_source;
      rsp_d.denied = denied;
      rsp_d.data   = (isGet && !denied) ? ramRdata : '0;
    end else if (dValid_q && auto_in_d_ready) begin
      dValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dValid_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      dValid_q <= dValid_d;
      rsp_q    <= rsp_d;
    end
  end

  assign auto_in_d_valid       = dValid_q;
  assign auto_in_d_bits_opcode = rsp_q.opcode;
  assign auto_in_d_bits_size   = rsp_q.size;
  assign auto_in_d_bits_source = rsp_q.source;
  assign auto_in_d_bits_denied = rsp_q.denied;
  assign auto_in_d_bits_data   = rsp_q.data;

endmodule

// File: tb/tb_tl_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_tl_ram_responder
// Drives TileLink-UL requests into tl_ram_responder. A monitor on the falling
// edge predicts each response from a reference RAM model when A fires and
// checks it against the D channel when D fires.
// -----------------------------------------------------------------------------
module tb_tl_ram_responder;

  localparam logic [35:0] BASE  = 36'h0_8000_0000;
  localparam int          DEPTH = 256;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic        src;
    logic        denied;
    logic [63:0] data;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic        a_source;
  logic [35:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic        d_source;
  logic        d_denied;
  logic [63:0] d_data;

  int   vectors     = 0;
  int   miscompares = 0;
  int   aFires      = 0;
  int   dFires      = 0;
  int   cycles      = 0;
  rsp_t expQ[$];
  rsp_t lastRsp;
  rsp_t monAct;
  rsp_t monExp;
  logic [63:0] modelMem [DEPTH];

  always #5 clock = ~clock;

  always @(posedge clock) cycles <= cycles + 1;

  tl_ram_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data)
  );

  // Reference model of one accepted request: predicts the response and
  // applies any write to the model RAM in acceptance order.
  task automatic modelAccept();
    logic [35:0] off;
    logic        inRange, aligned, opOk, denied, isGet;
    logic [7:0]  idx;
    rsp_t        e;
    off     = a_address - BASE;
    inRange = (a_address >= BASE) && (a_address < BASE + 36'd2048);
    aligned = (a_size <= 3'd3) && ((a_address & ((36'd1 << a_size) - 36'd1)) == 36'd0);
    opOk    = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
    denied  = !(inRange && aligned && opOk);
    isGet   = (a_opcode == 3'd4);
    idx     = off[10:3];
    e.op     = isGet ? 3'd1 : 3'd0;
    e.size   = a_size;
    e.src    = a_source;
    e.denied = denied;
    e.data   = (isGet && !denied) ? modelMem[idx] : 64'd0;
    expQ.push_back(e);
    if (!denied && !isGet) begin
      for (int i = 0; i < 8; i++) begin
        if (a_mask[i]) modelMem[idx][8*i +: 8] = a_data[8*i +: 8];
      end
    end
  endtask

  // Falling-edge monitor: D fire pops and checks, A fire predicts and pushes
  always @(negedge clock) begin
    if (reset) begin
      if (d_valid && d_ready) begin
        monAct = {d_opcode, d_size, d_source, d_denied, d_data};
        dFires++;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_response got=%h expected=none", monAct);
        end else begin
          monExp = expQ.pop_front();
          if (monAct !== monExp) begin
            miscompares++;
            $display("[TB] FAIL d_response got=%h expected=%h", monAct, monExp);
          end
        end
        lastRsp = monAct;
      end
      if (a_valid && a_ready) begin
        aFires++;
        modelAccept();
      end
    end
  end

  // Presents one request and returns just after the edge that accepts it,
  // leaving a_valid high so the caller can stream the next one.
  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic src,
                      input logic [35:0] addr, input logic [7:0] mask, input logic [63:0] data);
    logic fired;
    fired     = 1'b0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (a_ready) begin
        fired = 1'b1;
        break;
      end
    end
    if (!fired) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL a_accept_timeout got=no_fire expected=fire addr=%h", addr);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 50; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clock);
      #1;
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout got=%0d pending expected=0", expQ.size());
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_data} !== 73'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_d_outputs got=%h expected=0",
               {d_valid, d_opcode, d_size, d_source, d_denied, d_data});
    end
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_a_ready got=%b expected=1", a_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // PutFull then an immediately following Get of the same word
  task automatic test_put_get();
    send(3'd0, 3'd3, 1'b1, BASE + 36'h10, 8'hFF, 64'h1122334455667788);
    send(3'd4, 3'd3, 1'b0, BASE + 36'h10, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'h1122334455667788 || lastRsp.op !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL put_get_data got=%h/%0d expected=1122334455667788/1",
               lastRsp.data, lastRsp.op);
    end
  endtask

  task automatic test_out_of_range();
    send(3'd4, 3'd3, 1'b0, BASE + 36'h800, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.denied !== 1'b1 || lastRsp.data !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL oor_get_denied got=%b/%h expected=1/0", lastRsp.denied, lastRsp.data);
    end
    send(3'd0, 3'd3, 1'b1, BASE + 36'h800, 8'hFF, 64'hFFFF_0000_FFFF_0000);
    send(3'd0, 3'd3, 1'b1, BASE - 36'h8,   8'hFF, 64'hEEEE_EEEE_EEEE_EEEE);
    send(3'd0, 3'd3, 1'b0, BASE + 36'h7F8, 8'hFF, 64'h0123_4567_89AB_CDEF);
    send(3'd4, 3'd3, 1'b1, BASE + 36'h7F8, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'h0123_4567_89AB_CDEF || lastRsp.denied !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL last_word_get got=%h expected=0123456789abcdef", lastRsp.data);
    end
    send(3'd4, 3'd3, 1'b0, BASE + 36'h10, 8'hFF, 64'd0);
    send(3'd4, 3'd3, 1'b0, BASE + 36'h0,  8'hFF, 64'd0);
    send(3'd4, 3'd3, 1'b0, BASE + 36'h10, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'h1122334455667788) begin
      miscompares++;
      $display("[TB] FAIL oor_no_write got=%h expected=1122334455667788", lastRsp.data);
    end
  endtask

  task automatic test_partial();
    send(3'd1, 3'd3, 1'b1, BASE + 36'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    send(3'd4, 3'd3, 1'b1, BASE + 36'h10, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'h11223344BBBBBBBB) begin
      miscompares++;
      $display("[TB] FAIL partial_data got=%h expected=11223344bbbbbbbb", lastRsp.data);
    end
  endtask

  // Misaligned, illegal opcode and oversized size are denied; a legal
  // halfword write then changes exactly two lanes.
  task automatic test_illegal();
    send(3'd0, 3'd2, 1'b0, BASE + 36'h12, 8'hFF, 64'hDDDD_DDDD_DDDD_DDDD);
    send(3'd2, 3'd3, 1'b1, BASE + 36'h10, 8'hFF, 64'hCCCC_CCCC_CCCC_CCCC);
    send(3'd0, 3'd4, 1'b0, BASE + 36'h10, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB);
    drain();
    vectors++;
    if (lastRsp.denied !== 1'b1 || lastRsp.op !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL illegal_denied got=%b/%0d expected=1/0", lastRsp.denied, lastRsp.op);
    end
    send(3'd1, 3'd1, 1'b0, BASE + 36'h12, 8'h0C, 64'h0000_0000_5566_0000);
    send(3'd4, 3'd3, 1'b0, BASE + 36'h10, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'h11223344_5566BBBB) begin
      miscompares++;
      $display("[TB] FAIL illegal_no_write got=%h expected=112233445566bbbb", lastRsp.data);
    end
  endtask

  task automatic test_back_pressure();
    int   f0;
    rsp_t held;
    rsp_t now;
    f0      = aFires;
    d_ready = 1'b0;
    send(3'd4, 3'd3, 1'b1, BASE + 36'h10, 8'hFF, 64'd0);
    a_address = BASE + 36'h7F8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      now = {d_opcode, d_size, d_source, d_denied, d_data};
      if (i == 0) held = now;
      vectors++;
      if (a_ready !== 1'b0 || d_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_handshake cycle=%0d got=a_ready%b/d_valid%b expected=0/1",
                 i, a_ready, d_valid);
      end
      vectors++;
      if (now !== held) begin
        miscompares++;
        $display("[TB] FAIL bp_d_stable cycle=%0d got=%h expected=%h", i, now, held);
      end
    end
    vectors++;
    if (aFires - f0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL bp_single_fire got=%0d expected=1", aFires - f0);
    end
    @(posedge clock);
    #1;
    d_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (a_ready !== 1'b1 || d_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release got=a_ready%b/d_valid%b expected=1/1", a_ready, d_valid);
    end
    @(posedge clock);
    #1;
    drain();
    vectors++;
    if (aFires - f0 !== 2 || lastRsp.data !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("[TB] FAIL bp_second got=%0d/%h expected=2/0123456789abcdef",
               aFires - f0, lastRsp.data);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int d0;
    d0 = dFires;
    c0 = cycles;
    for (int k = 0; k < 8; k++) begin
      send(3'd0, 3'd3, k[0], BASE + 36'(k * 8) + 36'h20, 8'hFF, {32'hC0DE0000 + 32'(k), 32'(k * 7)});
      send(3'd4, 3'd3, k[0], BASE + 36'(k * 8) + 36'h20, 8'hFF, 64'd0);
    end
    vectors++;
    if (cycles - c0 !== 16) begin
      miscompares++;
      $display("[TB] FAIL stream_accept_cycles got=%0d expected=16", cycles - c0);
    end
    idle();
    @(posedge clock);
    #1;
    vectors++;
    if (dFires - d0 !== 16) begin
      miscompares++;
      $display("[TB] FAIL stream_responses got=%0d expected=16 in 17 cycles", dFires - d0);
    end
    drain();
  endtask

  task automatic test_async_reset();
    d_ready = 1'b0;
    send(3'd0, 3'd3, 1'b1, BASE + 36'h18, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    idle();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_data} !== 73'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_clear got=%h expected=0",
               {d_valid, d_opcode, d_size, d_source, d_denied, d_data});
    end
    expQ.delete();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_a_ready got=%b expected=1", a_ready);
    end
    d_ready = 1'b1;
    @(posedge clock);
    #1;
    send(3'd4, 3'd3, 1'b0, BASE + 36'h18, 8'hFF, 64'd0);
    drain();
    vectors++;
    if (lastRsp.data !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("[TB] FAIL ram_survives_reset got=%h expected=deadbeefcafef00d", lastRsp.data);
    end
  endtask

  initial begin
    reset     = 1'b0;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_size    = 3'd0;
    a_source  = 1'b0;
    a_address = 36'd0;
    a_mask    = 8'd0;
    a_data    = 64'd0;
    d_ready   = 1'b1;
    test_reset();
    test_put_get();
    test_out_of_range();
    test_partial();
    test_illegal();
    test_back_pressure();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_ram_responder.md
Name: tl_ram_responder

Overview:
- TileLink-UL slave endpoint that terminates the A channel and generates D-channel responses from a local word-addressed RAM.
- Sits downstream of a TL buffer as the leaf device of a crossbar port, for example a scratchpad or boot RAM.
- Supports Get, PutFullData and PutPartialData with single-beat, 64-bit transfers.
- Full throughput: one request per cycle when D is not back-pressured.

Parameters:
- DEPTH, 256, number of 64-bit words; power of two, minimum 2.
- BASE_ADDR, 36'h0_8000_0000, first byte address decoded; must be aligned to DEPTH*8.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- auto_in_a_ready  out  1  A-channel ready.
- auto_in_a_valid  in  1  A-channel valid.
- auto_in_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- auto_in_a_bits_size  in  3  log2 bytes; legal range 0..3.
- auto_in_a_bits_source  in  1  requester ID, echoed on D.
- auto_in_a_bits_address  in  36  byte address.
- auto_in_a_bits_mask  in  8  byte lanes to write.
- auto_in_a_bits_data  in  64  write data.
- auto_in_d_ready  in  1  D-channel ready.
- auto_in_d_valid  out  1  D-channel valid.
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- auto_in_d_bits_size  out  3  echoed size.
- auto_in_d_bits_source  out  1  echoed source.
- auto_in_d_bits_denied  out  1  request rejected.
- auto_in_d_bits_data  out  64  read data; 0 for AccessAck or denied.

Behaviour:
- Reset (reset=0, asynchronous): d_valid=0; d_opcode, d_size, d_source, d_denied and d_data all 0. RAM contents are not reset and are undefined after power-up.
- Ready: a_ready = !d_valid || d_ready, combinational from D state only. a_ready never depends on a_valid.
- A fire: a_valid && a_ready.
- On A fire, the response register loads at the next edge: d_valid=1, source and size echoed.
- Latency: the response is visible the cycle after A fire.
- With d_ready held high, back-to-back requests give one response per cycle.
- D fire without A fire: d_valid clears to 0.
- A fire and D fire in the same cycle: the register is overwritten with the new response; d_valid stays 1.
- D stability: while d_valid && !d_ready, all d_* outputs hold constant.
- Index: idx = (address - BASE_ADDR) >> 3, truncated to log2(DEPTH) bits.
- Denied is set, and no RAM write occurs, when any of these hold:
  - address is outside [BASE_ADDR, BASE_ADDR + DEPTH*8);
  - size > 3;
  - address is not aligned to 2^size;
  - opcode is not 0, 1 or 4.
- Denied responses return data=0. opcode is AccessAckData for Get and AccessAck otherwise.
- Get: d_opcode=1. d_data is the full 64-bit word at idx as it stood before any write in the same edge. The requester selects lanes.
- PutFullData and PutPartialData: d_opcode=0. Byte lane i is written with a_data[8i+7:8i] iff mask[i]=1. The write takes effect at the same edge that loads the response.
- Mask: not checked against size; the mask is trusted.
- Read-after-write ordering: a Get accepted the cycle after a Put to the same word returns the new data.
- Reset mid-operation: a pending response is discarded (d_valid=0). RAM keeps whatever was written before.

Decomposition:
- Package tl_pkg:
  - A opcodes: TL_A_PUTFULL=0, TL_A_PUTPARTIAL=1, TL_A_GET=4.
  - D opcodes: TL_D_ACCESSACK=0, TL_D_ACCESSACKDATA=1.
  - Width constants: ADDR_W=36, DATA_W=64, MASK_W=8, SIZE_W=3.
- Sub-module tl_ram_array:
  - DEPTH x 64 storage with byte-enable write.
  - Combinational read of the pre-write value.
  - No reset on the storage.
  - Keeps the top level to the handshake and decode logic.

Test Plan:
- PutFull, then Get:
  - Stimulus: Put opcode=0, addr=0x0_8000_0010, size=3, mask=0xFF, data=0x1122334455667788, source=1.
  - Response: next cycle D opcode=0, source=1, denied=0.
  - Then Get of the same address: returns data 0x1122334455667788, opcode=1.
- PutPartial:
  - Stimulus: opcode=1, same address, mask=0x0F, data=0xAAAAAAAA_BBBBBBBB.
  - Response: a following Get returns 0x11223344BBBBBBBB.
- Out of range:
  - Stimulus: Get at 0x0_8000_0800 with DEPTH=256.
  - Response: denied=1, data=0, opcode=1.
  - Put at the same address: denied=1, and a later in-range Get shows no RAM change.
- Misaligned and illegal opcode:
  - Stimulus: size=2 at addr offset 0x2; separately, opcode=2.
  - Response: both answered with denied=1 and no write.
- Back-pressure:
  - Stimulus: hold d_ready=0 for 5 cycles with a_valid=1.
  - Response: exactly one A fire, then a_ready=0. d_* are stable across those cycles.
  - On releasing d_ready, the next A fires in the same cycle as the D fire.
  - Streaming 16 requests with d_ready=1 yields 16 responses in 17 cycles.
- Async reset:
  - Stimulus: assert reset low between clock edges while d_valid=1.
  - Response: d_valid goes 0 immediately. After release, a_ready=1, and a Get returns data written before the reset.
